// File: rtl/synth_cfg_pkg.sv
// Shared constants for the synth config controller: register map, field widths, handshake states.
// Pure declarations; no logic, so there is no latency or backpressure to describe.
package synth_cfg_pkg;

  localparam int FCW_W      = 24;
  localparam int SHIFT_W    = 5;
  localparam int ADDR_W     = 5;
  localparam int MAX_VOICES = 16;

  localparam logic [ADDR_W-1:0] ADDR_MOD_FCW     = 5'd16;
  localparam logic [ADDR_W-1:0] ADDR_MOD_SHIFT   = 5'd17;
  localparam logic [ADDR_W-1:0] ADDR_NOTE_EN     = 5'd18;
  localparam logic [ADDR_W-1:0] ADDR_SYNTH_SHIFT = 5'd19;
  localparam logic [ADDR_W-1:0] ADDR_COMMIT      = 5'd20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

endpackage

// File: rtl/synth_cfg_req_fsm.sv
// Four-phase request FSM toward the CDC; req/busy are registered and rise one edge after start in IDLE.
// No backpressure of its own: start is ignored outside IDLE, and ack seen in IDLE is ignored.
module synth_cfg_req_fsm
  import synth_cfg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic busy
);

  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= REQ_HI;
            req   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ_HI: begin
          if (ack) begin
            state <= REQ_LO;
            req   <= 1'b0;
          end
        end
        REQ_LO: begin
          if (!ack) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/synth_cfg_ctrl.sv
// Synth config shadow registers with atomic snapshot commit to a CDC; snapshot and cfg_req update one edge after a commit.
// A commit during a transfer is queued (pending, coalesced); SYNTH_CFG_AUTO_COMMIT_EN makes every field write commit too.
module synth_cfg_ctrl
  import synth_cfg_pkg::*;
#(
  parameter int N_VOICES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [31:0]               wr_data,
  output logic [N_VOICES*FCW_W-1:0] cfg_carrier_fcws,
  output logic [FCW_W-1:0]          cfg_mod_fcw,
  output logic [SHIFT_W-1:0]        cfg_mod_shift,
  output logic [N_VOICES-1:0]       cfg_note_en,
  output logic [SHIFT_W-1:0]        cfg_synth_shift,
  output logic                      cfg_req,
  input  logic                      cfg_ack,
  output logic                      busy,
  output logic                      pending
);

`ifdef SYNTH_CFG_AUTO_COMMIT_EN
  localparam bit AUTO_COMMIT = 1'b1;
`else
  localparam bit AUTO_COMMIT = 1'b0;
`endif

  logic [N_VOICES*FCW_W-1:0] sh_fcws, sh_fcws_nxt, src_fcws;
  logic [FCW_W-1:0]          sh_mod_fcw, sh_mod_fcw_nxt, src_mod_fcw;
  logic [SHIFT_W-1:0]        sh_mod_shift, sh_mod_shift_nxt, src_mod_shift;
  logic [N_VOICES-1:0]       sh_note_en, sh_note_en_nxt, src_note_en;
  logic [SHIFT_W-1:0]        sh_synth_shift, sh_synth_shift_nxt, src_synth_shift;
  logic                      reg_hit;
  logic                      commit;
  logic                      launch;
  logic                      unused_wr_data;

  assign unused_wr_data = ^wr_data[31:FCW_W];

  always_comb begin
    sh_fcws_nxt        = sh_fcws;
    sh_mod_fcw_nxt     = sh_mod_fcw;
    sh_mod_shift_nxt   = sh_mod_shift;
    sh_note_en_nxt     = sh_note_en;
    sh_synth_shift_nxt = sh_synth_shift;
    reg_hit            = 1'b0;
    if (wr_en) begin
      for (int i = 0; i < N_VOICES; i++) begin
        if (wr_addr == 5'(i)) begin
          sh_fcws_nxt[i*FCW_W +: FCW_W] = wr_data[FCW_W-1:0];
          reg_hit = 1'b1;
        end
      end
      case (wr_addr)
        ADDR_MOD_FCW: begin
          sh_mod_fcw_nxt = wr_data[FCW_W-1:0];
          reg_hit = 1'b1;
        end
        ADDR_MOD_SHIFT: begin
          sh_mod_shift_nxt = wr_data[SHIFT_W-1:0];
          reg_hit = 1'b1;
        end
        ADDR_NOTE_EN: begin
          sh_note_en_nxt = wr_data[N_VOICES-1:0];
          reg_hit = 1'b1;
        end
        ADDR_SYNTH_SHIFT: begin
          sh_synth_shift_nxt = wr_data[SHIFT_W-1:0];
          reg_hit = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign commit = wr_en && ((wr_addr == ADDR_COMMIT) || (AUTO_COMMIT && reg_hit));
  assign launch = !busy && (commit || pending);

  // An auto-commit write must land in the snapshot it triggers; otherwise a
  // write coinciding with the snapshot edge is left for the next transfer.
  assign src_fcws        = AUTO_COMMIT ? sh_fcws_nxt        : sh_fcws;
  assign src_mod_fcw     = AUTO_COMMIT ? sh_mod_fcw_nxt     : sh_mod_fcw;
  assign src_mod_shift   = AUTO_COMMIT ? sh_mod_shift_nxt   : sh_mod_shift;
  assign src_note_en     = AUTO_COMMIT ? sh_note_en_nxt     : sh_note_en;
  assign src_synth_shift = AUTO_COMMIT ? sh_synth_shift_nxt : sh_synth_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_fcws          <= '0;
      sh_mod_fcw       <= '0;
      sh_mod_shift     <= '0;
      sh_note_en       <= '0;
      sh_synth_shift   <= '0;
      cfg_carrier_fcws <= '0;
      cfg_mod_fcw      <= '0;
      cfg_mod_shift    <= '0;
      cfg_note_en      <= '0;
      cfg_synth_shift  <= '0;
      pending          <= 1'b0;
    end else begin
      sh_fcws        <= sh_fcws_nxt;
      sh_mod_fcw     <= sh_mod_fcw_nxt;
      sh_mod_shift   <= sh_mod_shift_nxt;
      sh_note_en     <= sh_note_en_nxt;
      sh_synth_shift <= sh_synth_shift_nxt;
      if (launch) begin
        cfg_carrier_fcws <= src_fcws;
        cfg_mod_fcw      <= src_mod_fcw;
        cfg_mod_shift    <= src_mod_shift;
        cfg_note_en      <= src_note_en;
        cfg_synth_shift  <= src_synth_shift;
        pending          <= 1'b0;
      end else if (commit && busy) begin
        pending <= 1'b1;
      end
    end
  end

  synth_cfg_req_fsm u_req_fsm (
    .clk   (clk),
    .rst   (rst),
    .start (launch),
    .ack   (cfg_ack),
    .req   (cfg_req),
    .busy  (busy)
  );

endmodule

// File: tb/tb_synth_cfg_ctrl.sv
// Directed bench for synth_cfg_ctrl with two voices; the auto-commit build runs its own short sequence.
module tb_synth_cfg_ctrl;

  localparam int NV = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [NV*24-1:0] cfg_carrier_fcws;
  logic [23:0]      cfg_mod_fcw;
  logic [4:0]       cfg_mod_shift;
  logic [NV-1:0]    cfg_note_en;
  logic [4:0]       cfg_synth_shift;
  logic             cfg_req;
  logic             cfg_ack;
  logic             busy;
  logic             pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  synth_cfg_ctrl #(.N_VOICES(NV)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .cfg_carrier_fcws (cfg_carrier_fcws),
    .cfg_mod_fcw      (cfg_mod_fcw),
    .cfg_mod_shift    (cfg_mod_shift),
    .cfg_note_en      (cfg_note_en),
    .cfg_synth_shift  (cfg_synth_shift),
    .cfg_req          (cfg_req),
    .cfg_ack          (cfg_ack),
    .busy             (busy),
    .pending          (pending)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; cfg_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_req",     cfg_req, 0);
    check("rst_busy",    busy, 0);
    check("rst_pending", pending, 0);
    check("rst_fcws",    cfg_carrier_fcws, 0);
    check("rst_note_en", cfg_note_en, 0);

`ifdef SYNTH_CFG_AUTO_COMMIT_EN
    wr(5'd19, 32'd7);
    check("auto_req",   cfg_req, 1);
    check("auto_busy",  busy, 1);
    check("auto_shift", cfg_synth_shift, 7);
    cfg_ack = 1'b1; tick(); cfg_ack = 1'b0; tick();
    check("auto_idle",  busy, 0);
    wr(5'd0, 32'h00654321);
    check("auto_fcw0",  cfg_carrier_fcws, 48'h000000654321);
    check("auto_req2",  cfg_req, 1);
    cfg_ack = 1'b1; tick(); cfg_ack = 1'b0; tick();
`else
    // Shadow write alone must not reach the outputs
    wr(5'd0, 32'h00123456);
    tick(); tick();
    check("nocommit_fcws", cfg_carrier_fcws, 0);
    check("nocommit_req",  cfg_req, 0);
    check("nocommit_busy", busy, 0);

    // Basic commit; ack high for one cycle, req high for three
    wr(5'd18, 32'd1);
    wr(5'd20, 32'd0);
    check("c1_req1",    cfg_req, 1);
    check("c1_busy",    busy, 1);
    check("c1_fcws",    cfg_carrier_fcws, 48'h000000123456);
    check("c1_note_en", cfg_note_en, 2'b01);
    tick();
    check("c1_req2", cfg_req, 1);
    tick();
    check("c1_req3", cfg_req, 1);
    cfg_ack = 1'b1;
    tick();
    check("c1_req_drop", cfg_req, 0);
    check("c1_busy_lo",  busy, 1);
    cfg_ack = 1'b0;
    tick();
    check("c1_busy_end", busy, 0);
    check("c1_hold",     cfg_carrier_fcws, 48'h000000123456);

    // Unmapped voice address and a stray ack in IDLE
    wr(5'd5, 32'hFFFFFFFF);
    cfg_ack = 1'b1; tick(); cfg_ack = 1'b0; tick();
    check("idle_busy",    busy, 0);
    check("idle_req",     cfg_req, 0);
    check("idle_pending", pending, 0);
    check("idle_fcws",    cfg_carrier_fcws, 48'h000000123456);

    // Commits during REQ_HI coalesce into one queued transfer
    wr(5'd1, 32'h000000AA);
    wr(5'd20, 32'd0);
    check("c2_req",  cfg_req, 1);
    check("c2_fcws", cfg_carrier_fcws, 48'h0000AA123456);
    wr(5'd16, 32'h00ABCDEF);
    check("c2_mod_hold", cfg_mod_fcw, 0);
    check("c2_no_pend",  pending, 0);
    wr(5'd20, 32'd0);
    check("c2_pend1", pending, 1);
    wr(5'd20, 32'd0);
    check("c2_pend2", pending, 1);
    wr(5'd19, 32'd3);
    check("c2_mod_hold2",   cfg_mod_fcw, 0);
    check("c2_shift_hold",  cfg_synth_shift, 0);
    check("c2_fcws_hold",   cfg_carrier_fcws, 48'h0000AA123456);
    cfg_ack = 1'b1;
    tick();
    check("c2_lo_req",  cfg_req, 0);
    check("c2_lo_pend", pending, 1);
    check("c2_lo_busy", busy, 1);
    cfg_ack = 1'b0;
    tick();
    check("c2_idle_busy", busy, 0);
    check("c2_idle_pend", pending, 1);
    check("c2_idle_req",  cfg_req, 0);
    // Write in the launch cycle is excluded from this snapshot
    wr(5'd17, 32'd9);
    check("c3_req",       cfg_req, 1);
    check("c3_pend_clr",  pending, 0);
    check("c3_mod_fcw",   cfg_mod_fcw, 24'hABCDEF);
    check("c3_shift",     cfg_synth_shift, 3);
    check("c3_mod_shift", cfg_mod_shift, 0);
    cfg_ack = 1'b1; tick(); cfg_ack = 1'b0; tick();
    tick(); tick();
    check("c3_no_third_req",  cfg_req, 0);
    check("c3_no_third_busy", busy, 0);
    check("c3_no_third_pend", pending, 0);

    wr(5'd20, 32'd0);
    check("c4_mod_shift", cfg_mod_shift, 9);
    tick();

    // Reset in REQ_HI with a commit pending
    wr(5'd20, 32'd0);
    check("r_pend_set", pending, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_req",       cfg_req, 0);
    check("r_busy",      busy, 0);
    check("r_pending",   pending, 0);
    check("r_fcws",      cfg_carrier_fcws, 0);
    check("r_mod_fcw",   cfg_mod_fcw, 0);
    check("r_mod_shift", cfg_mod_shift, 0);
    check("r_note_en",   cfg_note_en, 0);
    check("r_shift",     cfg_synth_shift, 0);
    wr(5'd20, 32'd0);
    check("r_commit_req",  cfg_req, 1);
    check("r_commit_fcws", cfg_carrier_fcws, 0);
    check("r_commit_mod",  cfg_mod_fcw, 0);
    cfg_ack = 1'b1; tick(); cfg_ack = 1'b0; tick(); tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
